mux_key_table_arb: RTL
======================

Name: mux_key_table_arb

Overview:
- Programmable key→data lookup table with round-robin arbitration between two requesters and a registered, back-pressurable response stage.
- Gives the key-match mux a runtime-writable key/data table and a default value.
- Sequences lookups from two clients, one per cycle.
- Sits between a configuration master (cfg_*) and two lookup clients (req0/req1).

Parameters:
- NR_KEY, 4, number of table entries (≥1)
- KEY_LEN, 4, key width in bits
- DATA_LEN, 8, data width in bits
- IDX_W (localparam), max(1, $clog2(NR_KEY)), entry index width

Ports:
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- cfg_we  input  1  write one table entry this cycle
- cfg_idx  input  IDX_W  entry index to write
- cfg_key  input  KEY_LEN  key for written entry
- cfg_data  input  DATA_LEN  data for written entry
- cfg_vld  input  1  valid bit for written entry (0 = invalidate)
- cfg_def_we  input  1  write default register
- cfg_def_data  input  DATA_LEN  new default value
- cfg_clear  input  1  invalidate all entries
- req0_valid  input  1  requester 0 lookup valid
- req0_key  input  KEY_LEN  requester 0 key
- req0_ready  output  1  requester 0 accepted when valid&ready
- req1_valid  input  1  requester 1 lookup valid
- req1_key  input  KEY_LEN  requester 1 key
- req1_ready  output  1  requester 1 accepted when valid&ready
- rsp_valid  output  1  response valid
- rsp_ready  input  1  response consumer ready
- rsp_id  output  1  requester that issued this response
- rsp_hit  output  1  1 = a valid entry matched
- rsp_data  output  DATA_LEN  matched data, or default on miss

Behaviour:
- Reset (async assert, sync release by design):
  - All entry valid/key/data = 0; default register = 0.
  - rsp_valid = 0; rsp_id = 0; rsp_hit = 0; rsp_data = 0.
  - Round-robin pointer last_grant = 1, so req0 wins the first contention.
- Reset mid-operation discards the in-flight response and all table contents.
- Config:
  - cfg_we writes {vld, key, data} of entry cfg_idx at the clock edge.
  - cfg_idx ≥ NR_KEY: write ignored.
  - cfg_clear clears every valid bit.
  - cfg_clear and cfg_we in the same cycle: clear applies first, then the write; the written entry takes cfg_vld.
  - cfg_def_we updates the default register.
- Response stage: single register, states EMPTY (rsp_valid=0) and FULL (rsp_valid=1).
  - can_accept = !rsp_valid | rsp_ready.
  - EMPTY→FULL on a grant.
  - FULL→EMPTY on rsp_ready with no grant.
  - FULL→FULL (new contents) on rsp_ready with a grant.
  - FULL holds while rsp_ready=0; response fields are stable until consumed.
- Arbitration (combinational, same cycle):
  - Only req0 valid: grant 0. Only req1 valid: grant 1.
  - Both valid: grant !last_grant.
  - reqN_ready = can_accept & grant==N. Exactly one ready may be high; ready never depends on the other requester being absent beyond this rule.
  - last_grant updates only on an accepted transfer.
- Lookup:
  - Compare the accepted key against every valid entry using table contents before this edge's config writes (a same-cycle write is not visible).
  - Lowest matching index wins; hit = any valid match.
  - rsp_data = hit ? entry data : default register value (pre-write value).
  - Latency: accept at edge N → rsp_valid, rsp_id, rsp_hit, rsp_data valid after edge N.
  - Throughput: 1 lookup/cycle with rsp_ready held high.
- Widths: keys compared at full KEY_LEN; no truncation or extension anywhere.

Test Plan:
- Reset, then write idx0 {key=3, data=0xA5, vld=1}; req0 key=3 → next cycle rsp_valid=1, rsp_id=0, rsp_hit=1, rsp_data=0xA5.
- Write default=0x5A; req1 key=7 (no match) → rsp_hit=0, rsp_data=0x5A, rsp_id=1. Then cfg_clear; req0 key=3 → rsp_hit=0, rsp_data=0x5A.
- req0 and req1 both held valid, rsp_ready=1, 4 cycles → grants 0,1,0,1; rsp_id sequence 0,1,0,1, one response per cycle.
- rsp_ready=0 with response FULL for 3 cycles while both requesters valid → req0_ready=req1_ready=0; rsp fields unchanged. Raise rsp_ready → next grant resumes round-robin from the pointer.
- Entries 1 and 2 both key=5, data 0x11/0x22 → lookup key 5 returns 0x11. Same-cycle cfg_we of idx1 to data 0x33 plus a lookup → 0x11; following lookup → 0x33.
- cfg_we with cfg_idx=NR_KEY (when NR_KEY is not a power of 2, e.g. NR_KEY=3) → table unchanged. Assert rst_n low while FULL → rsp_valid=0 immediately; all entries invalid.

Source files
------------

// File: rtl/mux_key_table_arb.sv
// Runtime-programmable key->data lookup table shared by two round-robin
// arbitrated requesters, with a single registered, back-pressurable response.
module mux_key_table_arb #(
    parameter  int NR_KEY   = 4,
    parameter  int KEY_LEN  = 4,
    parameter  int DATA_LEN = 8,
    localparam int IDX_W    = (NR_KEY > 1) ? $clog2(NR_KEY) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cfg_we,
    input  logic [IDX_W-1:0]    cfg_idx,
    input  logic [KEY_LEN-1:0]  cfg_key,
    input  logic [DATA_LEN-1:0] cfg_data,
    input  logic                cfg_vld,
    input  logic                cfg_def_we,
    input  logic [DATA_LEN-1:0] cfg_def_data,
    input  logic                cfg_clear,
    input  logic                req0_valid,
    input  logic [KEY_LEN-1:0]  req0_key,
    output logic                req0_ready,
    input  logic                req1_valid,
    input  logic [KEY_LEN-1:0]  req1_key,
    output logic                req1_ready,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic                rsp_id,
    output logic                rsp_hit,
    output logic [DATA_LEN-1:0] rsp_data
);

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } rsp_state_t;

    logic                r_vld  [NR_KEY];
    logic [KEY_LEN-1:0]  r_key  [NR_KEY];
    logic [DATA_LEN-1:0] r_data [NR_KEY];
    logic [DATA_LEN-1:0] r_def;

    rsp_state_t          r_state;
    logic                r_rsp_id;
    logic                r_rsp_hit;
    logic [DATA_LEN-1:0] r_rsp_data;
    logic                r_last_grant;

    logic                w_can_accept;
    logic                w_any_req;
    logic                w_grant;
    logic                w_fire;
    logic [KEY_LEN-1:0]  w_key;
    logic                w_hit;
    logic [DATA_LEN-1:0] w_hit_data;

    assign w_can_accept = (r_state == S_EMPTY) | rsp_ready;
    assign w_any_req    = req0_valid | req1_valid;
    assign w_fire       = w_can_accept & w_any_req;

    // Contention alternates away from the last accepted requester.
    always_comb begin
        w_grant = 1'b0;
        if (req0_valid && req1_valid) begin
            w_grant = ~r_last_grant;
        end else if (req1_valid) begin
            w_grant = 1'b1;
        end
    end

    assign req0_ready = w_can_accept & ~w_grant;
    assign req1_ready = w_can_accept &  w_grant;
    assign w_key      = w_grant ? req1_key : req0_key;

    // Descending scan so the lowest matching index is the one that sticks.
    always_comb begin
        w_hit      = 1'b0;
        w_hit_data = r_def;
        for (int i = NR_KEY - 1; i >= 0; i--) begin
            if (r_vld[i] && (r_key[i] == w_key)) begin
                w_hit      = 1'b1;
                w_hit_data = r_data[i];
            end
        end
    end

    // A same-cycle clear and write leaves the written entry with cfg_vld.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NR_KEY; i++) begin
                r_vld[i]  <= 1'b0;
                r_key[i]  <= '0;
                r_data[i] <= '0;
            end
            r_def <= '0;
        end else begin
            for (int i = 0; i < NR_KEY; i++) begin
                if (cfg_clear) begin
                    r_vld[i] <= 1'b0;
                end
                if (cfg_we && (cfg_idx == IDX_W'(i))) begin
                    r_vld[i]  <= cfg_vld;
                    r_key[i]  <= cfg_key;
                    r_data[i] <= cfg_data;
                end
            end
            if (cfg_def_we) begin
                r_def <= cfg_def_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_EMPTY;
            r_rsp_id     <= 1'b0;
            r_rsp_hit    <= 1'b0;
            r_rsp_data   <= '0;
            r_last_grant <= 1'b1;
        end else if (w_fire) begin
            r_state      <= S_FULL;
            r_rsp_id     <= w_grant;
            r_rsp_hit    <= w_hit;
            r_rsp_data   <= w_hit_data;
            r_last_grant <= w_grant;
        end else if (rsp_ready) begin
            r_state <= S_EMPTY;
        end
    end

    assign rsp_valid = (r_state == S_FULL);
    assign rsp_id    = r_rsp_id;
    assign rsp_hit   = r_rsp_hit;
    assign rsp_data  = r_rsp_data;

endmodule
